// File: rtl/sos_sample_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sos_sample_driver_if
// Brief    : Input stream, filter handshake and output stream of the biquad
//            sample driver, bundled with driver/environment views.
// Revision : 1.0 - initial release
// ============================================================================
interface sos_sample_driver_if #(
    parameter int DATA_SIZE = 24
);
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] flt_data_in;
    logic                 flt_sample_trig;
    logic                 flt_filter_done;
    logic [DATA_SIZE-1:0] flt_data_out;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 timeout_err;
    logic                 busy;

    // Driver side
    modport master (
        input  in_data, in_valid, flt_filter_done, flt_data_out, out_ready,
        output in_ready, flt_data_in, flt_sample_trig, out_data, out_valid,
               timeout_err, busy
    );

    // Sample source, filter and downstream consumer
    modport slave (
        output in_data, in_valid, flt_filter_done, flt_data_out, out_ready,
        input  in_ready, flt_data_in, flt_sample_trig, out_data, out_valid,
               timeout_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/sos_sample_driver.sv
`default_nettype none
// ============================================================================
// Module   : sos_sample_driver
// Brief    : FIFO-buffered sequencer that triggers one filter_sos computation
//            per sample and streams the captured results out.
// Revision : 1.0 - initial release
// ============================================================================
module sos_sample_driver #(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sos_sample_driver_if.master bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TRIG      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_CAPTURE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [DATA_SIZE-1:0] r_flt_data_in;
    logic                 r_trig;
    logic [DATA_SIZE-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_timeout_err;

    logic w_in_ready;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_load;

    // Ready comes only from the registered count: a full FIFO refuses a push
    // even when the FSM pops in the same cycle.
    assign w_in_ready = (r_count != c_CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_load     = (r_state == S_CAPTURE) && (!r_out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_flt_data_in <= '0;
            r_trig        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_flt_data_in <= r_mem[r_rd_ptr];
                        r_trig        <= 1'b1;
                        r_state       <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    r_trig   <= 1'b0;
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.flt_filter_done) begin
                        r_state <= S_CAPTURE;
                    end else if (r_to_cnt == c_TO_W'(TIMEOUT - 1)) begin
                        // The sample is dropped; the filter is not re-armed.
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (w_load) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A capture load wins over a simultaneous downstream acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= bus.flt_data_out;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.flt_data_in     = r_flt_data_in;
    assign bus.flt_sample_trig = r_trig;
    assign bus.out_data        = r_out_data;
    assign bus.out_valid       = r_out_valid;
    assign bus.timeout_err     = r_timeout_err;
    assign bus.busy            = (r_state != S_IDLE) || !w_empty || r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_sos_sample_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sos_sample_driver
// Brief    : Directed self-checking bench for sos_sample_driver with a
//            unity-gain behavioural filter_sos model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sos_sample_driver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sos_sample_driver_if #(.DATA_SIZE(24)) bus ();

    sos_sample_driver #(
        .DATA_SIZE (24),
        .FIFO_DEPTH(4),
        .TIMEOUT   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Unity filter: S1 after trigger, done in S2, data_out valid from S3 on
    logic [1:0]  phase     = 2'd0;
    logic [23:0] latched   = '0;
    logic [23:0] model_out = '0;
    logic        kill_done = 1'b0;

    always @(posedge clk) begin
        if (bus.flt_sample_trig) begin
            latched <= bus.flt_data_in;
            phase   <= 2'd1;
        end else if (phase == 2'd1) begin
            phase <= 2'd2;
        end else if (phase == 2'd2) begin
            phase     <= 2'd3;
            model_out <= latched;
        end else if (phase == 2'd3) begin
            phase <= 2'd0;
        end
    end

    assign bus.flt_filter_done = (phase == 2'd2) && !kill_done;
    assign bus.flt_data_out    = model_out;

    int          cyc = 0;
    int          trig_cyc[$];
    logic [23:0] outq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.flt_sample_trig) trig_cyc.push_back(cyc);
        if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        trig_cyc.delete();
        outq.delete();
    endtask

    task automatic push_one(input logic [23:0] d, output int stalls);
        stalls       = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && stalls < 50) begin
            step();
            stalls++;
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input string tag);
        int k = 0;
        while (outq.size() < n && k < 300) begin
            step();
            k++;
        end
        chk(tag, outq.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] bv[6];
        logic [23:0] bp[3];
        logic [23:0] qv[12];
        int          st;
        int          stall[6];

        bv = '{24'hA00001, 24'hB00002, 24'hC00003, 24'hD00004, 24'hE00005, 24'hF00006};
        bp = '{24'h123456, 24'h789ABC, 24'hFEDCBA};
        for (int i = 0; i < 12; i++) qv[i] = 24'(32'h5A0000 + i * 32'h1111);

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_trig", 32'(bus.flt_sample_trig), 0);
        chk("rst_data_in", 32'(bus.flt_data_in), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_timeout", 32'(bus.timeout_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b1;
        step();

        // Single sample: pop, trig, 2x wait, capture, out_valid 5 cycles after pop
        clear_logs();
        bus.in_data  = 24'h000100;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_trig_pre", 32'(bus.flt_sample_trig), 0);
        step();
        chk("t1_trig", 32'(bus.flt_sample_trig), 1);
        chk("t1_data_in", 32'(bus.flt_data_in), 'h100);
        step();
        chk("t1_trig_one", 32'(bus.flt_sample_trig), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_hold", 32'(bus.flt_data_in), 'h100);
            chk("t1_no_valid", 32'(bus.out_valid), 0);
            step();
        end
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_out_data", 32'(bus.out_data), 'h100);
        chk("t1_hold_end", 32'(bus.flt_data_in), 'h100);
        step();
        chk("t1_valid_clr", 32'(bus.out_valid), 0);
        chk("t1_trig_cnt", trig_cyc.size(), 1);
        chk("t1_out_cnt", outq.size(), 1);

        // Burst of 6 with the FIFO filling behind a busy FSM
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            push_one(bv[i], st);
            stall[i] = st;
            if (i == 4) chk("t2_full", 32'(bus.in_ready), 0);
        end
        for (int i = 0; i < 5; i++) chk("t2_no_stall", stall[i], 0);
        chk("t2_s6_stall", stall[5], 2);
        wait_outs(6, "t2_out_cnt");
        for (int i = 0; i < 6; i++) chk("t2_order", 32'(outq[i]), 32'(bv[i]));
        chk("t2_trig_cnt", trig_cyc.size(), 6);
        for (int i = 0; i < 5; i++) chk("t2_trig_gap", trig_cyc[i+1] - trig_cyc[i], 5);
        repeat (3) step();

        // Backpressure: first result held, second pending in CAPTURE
        clear_logs();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(bp[i], st);
        repeat (20) step();
        chk("t3_valid_held", 32'(bus.out_valid), 1);
        chk("t3_data_held", 32'(bus.out_data), 32'(bp[0]));
        chk("t3_trig_stalled", trig_cyc.size(), 2);
        chk("t3_data_in", 32'(bus.flt_data_in), 32'(bp[1]));
        chk("t3_in_ready", 32'(bus.in_ready), 1);
        chk("t3_busy", 32'(bus.busy), 1);
        bus.out_ready = 1'b1;
        wait_outs(3, "t3_out_cnt");
        for (int i = 0; i < 3; i++) chk("t3_order", 32'(outq[i]), 32'(bp[i]));
        repeat (10) step();
        chk("t3_no_dup", outq.size(), 3);
        chk("t3_trig_cnt", trig_cyc.size(), 3);
        chk("t3_no_timeout", 32'(bus.timeout_err), 0);

        // Timeout after 8 WAIT_DONE cycles, then recovery
        clear_logs();
        kill_done    = 1'b1;
        bus.in_data  = 24'h0BAD01;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        chk("t4_err_early", 32'(bus.timeout_err), 0);
        chk("t4_busy_wait", 32'(bus.busy), 1);
        step();
        chk("t4_err", 32'(bus.timeout_err), 1);
        chk("t4_idle", 32'(bus.busy), 0);
        chk("t4_no_valid", 32'(bus.out_valid), 0);
        repeat (3) step();
        chk("t4_no_out", outq.size(), 0);
        kill_done = 1'b0;
        push_one(24'h00C0DE, st);
        wait_outs(1, "t4_recover_cnt");
        chk("t4_recover_data", 32'(outq[0]), 'h00C0DE);
        chk("t4_err_sticky", 32'(bus.timeout_err), 1);
        chk("t4_trig_cnt", trig_cyc.size(), 2);
        repeat (3) step();

        // Asynchronous reset while in WAIT_DONE with two samples queued
        clear_logs();
        push_one(24'h111111, st);
        push_one(24'h222222, st);
        push_one(24'h333333, st);
        chk("t5_trig_before", trig_cyc.size(), 1);
        reset = 1'b0;
        #1;
        chk("t5_in_ready", 32'(bus.in_ready), 1);
        chk("t5_trig", 32'(bus.flt_sample_trig), 0);
        chk("t5_data_in", 32'(bus.flt_data_in), 0);
        chk("t5_out_data", 32'(bus.out_data), 0);
        chk("t5_out_valid", 32'(bus.out_valid), 0);
        chk("t5_timeout", 32'(bus.timeout_err), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) step();
        chk("t5_fifo_empty", trig_cyc.size(), 1);
        chk("t5_busy_after", 32'(bus.busy), 0);
        chk("t5_no_out", outq.size(), 0);

        // Push aligned with every pop keeps two entries queued; wrap ordering
        clear_logs();
        for (int i = 0; i < 3; i++) push_one(qv[i], st);
        for (int k = 3; k < 10; k++) begin
            repeat (k == 3 ? 3 : 4) step();
            push_one(qv[k], st);
            chk("t6_pop_aligned", 32'(bus.flt_sample_trig), 1);
            chk("t6_in_ready", 32'(bus.in_ready), 1);
        end
        push_one(qv[10], st);
        chk("t6_count3", 32'(bus.in_ready), 1);
        push_one(qv[11], st);
        chk("t6_count4_full", 32'(bus.in_ready), 0);
        wait_outs(12, "t6_out_cnt");
        for (int i = 0; i < 12; i++) chk("t6_order", 32'(outq[i]), 32'(qv[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
